// File: rtl/matrix_result_serializer.sv
// matrix_result_serializer: captures the 3x3 multiplier result and streams it
// as HDR_BYTE, data bytes, XOR checksum over a valid/ack byte handshake with a
// mandatory one-cycle gap after every ack.
// Optional build macro SER_FULL_WIDTH_EN: send each element as two bytes
// (MSB first) instead of one mapped byte.
module matrix_result_serializer #(
  parameter int         ELEM_W   = 16,
  parameter int         N_ELEM   = 9,
  parameter logic [7:0] HDR_BYTE = 8'hA5,
  parameter bit         SAT      = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [ELEM_W*N_ELEM-1:0] c_flat,
  input  logic                     out_ack,
  output logic                     out_valid,
  output logic [7:0]               out_byte,
  output logic                     busy,
  output logic                     done
);

`ifdef SER_FULL_WIDTH_EN
  localparam int NBYTES = 2 * N_ELEM;
`else
  localparam int NBYTES = N_ELEM;
`endif
  localparam int IW = $clog2(NBYTES + 1);
  localparam int EW = $clog2(N_ELEM);

  typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;

  state_t                     state, state_nxt;
  logic [ELEM_W*N_ELEM-1:0]   data_q;
  logic [IW-1:0]              idx;
  logic [7:0]                 csum;
  logic                       gap;
  logic                       ack_ok;
  logic                       last_data;
  logic [EW-1:0]              eidx;
  logic [ELEM_W-1:0]          e;
  logic [7:0]                 data_byte;
  logic [ELEM_W-1:0]          elem [N_ELEM];

  // Row-major element view of the latched result, element 0 in the top bits.
  for (genvar g = 0; g < N_ELEM; g++) begin : g_elem
    assign elem[g] = data_q[ELEM_W*N_ELEM-1-ELEM_W*g -: ELEM_W];
  end

  // A byte is offered whenever a frame is active, except in the gap cycle after an ack.
  assign out_valid = (state != IDLE) && !gap;
  assign busy      = (state != IDLE);
  assign ack_ok    = out_ack && out_valid;
  assign last_data = (idx == IW'(NBYTES - 1));

  // Select the current data byte from the byte index.
  always_comb begin
    data_byte = 8'h00;
`ifdef SER_FULL_WIDTH_EN
    eidx = EW'(idx >> 1);
    e    = elem[eidx];
    data_byte = idx[0] ? e[7:0] : e[15:8];
`else
    eidx = EW'(idx);
    e    = elem[eidx];
    if (SAT && (|e[ELEM_W-1:8])) data_byte = 8'hFF;
    else                         data_byte = e[7:0];
`endif
  end

  // Output byte mux; IDLE drives zero so reset leaves the bus quiet.
  always_comb begin
    out_byte = 8'h00;
    case (state)
      HDR:     out_byte = HDR_BYTE;
      DATA:    out_byte = data_byte;
      CSUM:    out_byte = csum;
      default: out_byte = 8'h00;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: advance only on an ack that lands on a valid byte.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load)                 state_nxt = HDR;
      HDR:  if (ack_ok)               state_nxt = DATA;
      DATA: if (ack_ok && last_data)  state_nxt = CSUM;
      CSUM: if (ack_ok)               state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Datapath: latch on accepted load, accumulate checksum per data ack, gap and done pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
      idx    <= '0;
      csum   <= 8'h00;
      gap    <= 1'b0;
      done   <= 1'b0;
    end else begin
      gap  <= ack_ok;
      done <= (state == CSUM) && ack_ok;
      if (state == IDLE && load) begin
        data_q <= c_flat;
        idx    <= '0;
        csum   <= 8'h00;
      end
      if (state == DATA && ack_ok) begin
        csum <= csum ^ data_byte;
        idx  <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Scoreboard bench for matrix_result_serializer: the stimulus pushes each
// frame's expected bytes, a monitor pops them as the DUT presents bytes.
module tb_matrix_result_serializer;
  localparam int ELEM_W = 16;
  localparam int N_ELEM = 9;
  localparam bit SAT    = 1'b1;
`ifdef SER_FULL_WIDTH_EN
  localparam int DBYTES = 2 * N_ELEM;
`else
  localparam int DBYTES = N_ELEM;
`endif

  typedef logic [15:0] elems_t [N_ELEM];

  logic clk = 1'b0, rst = 1'b0, load = 1'b0, out_ack = 1'b0;
  logic [ELEM_W*N_ELEM-1:0] c_flat = '0;
  logic out_valid, busy, done;
  logic [7:0] out_byte;

  int tests = 0, fails = 0;
  int done_seen = 0, done_exp = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  matrix_result_serializer #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM), .HDR_BYTE(8'hA5), .SAT(SAT)) dut (
    .clk(clk), .rst(rst), .load(load), .c_flat(c_flat), .out_ack(out_ack),
    .out_valid(out_valid), .out_byte(out_byte), .busy(busy), .done(done)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference frame: header, mapped data bytes, XOR of data bytes.
  function automatic void model_frame(input elems_t e);
    logic [7:0] cs = 8'h00;
    logic [7:0] b;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < N_ELEM; k++) begin
`ifdef SER_FULL_WIDTH_EN
      b = e[k] / 256;   exp_q.push_back(b); cs ^= b;
      b = e[k] % 256;   exp_q.push_back(b); cs ^= b;
`else
      b = (SAT && e[k] > 16'd255) ? 8'hFF : 8'(e[k] % 256);
      exp_q.push_back(b); cs ^= b;
`endif
    end
    exp_q.push_back(cs);
  endfunction

  task automatic scramble_cflat();
    for (int k = 0; k < N_ELEM; k++) c_flat[ELEM_W*N_ELEM-1-ELEM_W*k -: ELEM_W] = 16'($urandom);
  endtask

  // Monitor: pops one expected byte per new valid, checks hold, gap and done width.
  initial begin
    logic pv = 1'b0, pa = 1'b0, pd = 1'b0;
    logic [7:0] pb = 8'h00;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (pa) check("gap_after_ack", out_valid, 1'b0);
        if (out_valid && !pv) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_byte: got %0h expected none at %0t", out_byte, $time);
          end else begin
            eb = exp_q.pop_front();
            check("byte", out_byte, eb);
          end
        end else if (out_valid && pv) begin
          check("byte_hold", out_byte, pb);
        end
        if (done) begin
          done_seen++;
          if (pd) check("done_width", 1'b0, 1'b1);
        end
      end
      pv = out_valid; pb = out_byte; pa = out_ack && out_valid; pd = done;
    end
  end

  // Drive one frame; dly<0 means random ack delay; ack_n<0 means ack all bytes.
  task automatic run_frame(input elems_t e, input int dly, input bit abuse, input int ack_n);
    int n, lim, cnt, d;
    bit last;
    n   = DBYTES + 2;
    lim = (ack_n < 0) ? n : ack_n;
    for (int k = 0; k < N_ELEM; k++) c_flat[ELEM_W*N_ELEM-1-ELEM_W*k -: ELEM_W] = e[k];
    model_frame(e);
    load = 1'b1;
    @(posedge clk) #1;
    load = 1'b0;
    scramble_cflat();
    check("load_latency", out_valid, 1'b1);
    check("busy_after_load", busy, 1'b1);
    for (int b = 0; b < lim; b++) begin
      cnt = 0;
      while (!out_valid && cnt < 20) begin @(posedge clk) #1; cnt++; end
      check("wait_valid", out_valid, 1'b1);
      if (!out_valid) return;
      d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
      repeat (d) @(posedge clk) #1;
      last = (b == n - 1);
      out_ack = 1'b1;
      if (abuse && last) load = 1'b1;
      @(posedge clk) #1;
      out_ack = 1'b0; load = 1'b0;
      if (last) begin
        check("done_on_last", done, 1'b1);
        check("busy_clear", busy, 1'b0);
        done_exp++;
      end else if (abuse) begin
        out_ack = 1'b1; load = 1'b1; scramble_cflat();
        @(posedge clk) #1;
        out_ack = 1'b0; load = 1'b0;
      end
    end
    if (lim == n) begin
      repeat (2) @(posedge clk) #1;
      check("idle_after_frame", out_valid, 1'b0);
    end
  endtask

  initial begin
    elems_t e;
    // Reset held with load asserted: everything stays quiet.
    rst = 1'b0; load = 1'b1; scramble_cflat();
    repeat (3) begin
      @(posedge clk) #1;
      check("rst_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_byte", out_byte, 8'h00);
    end
    load = 1'b0; rst = 1'b1;
    @(posedge clk) #1;

    // Elements 1..9, acked 3 clocks after valid.
    for (int k = 0; k < N_ELEM; k++) e[k] = 16'(k + 1);
    run_frame(e, 3, 1'b0, -1);

    // Saturation boundary on element 0.
    for (int k = 0; k < N_ELEM; k++) e[k] = 16'h0000;
    e[0] = 16'h0123;
    run_frame(e, -1, 1'b0, -1);

    // Full-scale boundary values at both ends.
    e[0] = 16'h00FF; e[N_ELEM-1] = 16'h0100;
    run_frame(e, 0, 1'b0, -1);

    // Random frames, alternating protocol abuse.
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < N_ELEM; k++) e[k] = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      run_frame(e, -1, 1'(f % 2), -1);
    end

    // Reset after header + 4 data bytes acked, then a fresh frame.
    for (int k = 0; k < N_ELEM; k++) e[k] = 16'($urandom);
    run_frame(e, -1, 1'b0, 5);
    rst = 1'b0;
    @(posedge clk) #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_byte", out_byte, 8'h00);
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk) #1;
    for (int k = 0; k < N_ELEM; k++) e[k] = 16'($urandom);
    run_frame(e, -1, 1'b0, -1);

    repeat (3) @(posedge clk) #1;
    check("done_count", done_seen, done_exp);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
